// File: rtl/lapido_fetch_queue.sv
// ---------------------------------------------------------------------------
// lapido_fetch_queue
//
// Instruction fetch queue sitting between the IF and ID stages. It holds up
// to DEPTH {pc, instruction} pairs in a circular buffer. Both sides use a
// valid/ready handshake, so IF can keep fetching while ID is stalled. A
// redirect (flush) empties the queue in a single cycle.
//
// Optional build macro:
//   LAPIDO_FQ_BYPASS_EN - when the queue is empty and ID is ready, the
//                         incoming word goes straight to the outputs in the
//                         same cycle. It is consumed there and never written.
//
// Ports:
//   clk             clock; all state updates on the rising edge
//   rst             asynchronous reset, active-high
//   in_valid        IF presents a fetched instruction
//   in_instruction  fetched word
//   in_pc           PC of the fetched word
//   in_ready        queue can accept a push (depends on registered state only)
//   out_valid       head entry valid for ID
//   out_instruction head instruction; zero (NOP) when out_valid=0
//   out_pc          head PC; zero when out_valid=0
//   out_ready       ID consumes the head (driven as !stall_pipeline)
//   flush           redirect; discard all entries, takes priority
//   count           current occupancy
// ---------------------------------------------------------------------------
module lapido_fetch_queue #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 32,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [INSTR_WIDTH-1:0]   in_instruction,
  input  logic [PC_WIDTH-1:0]      in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [INSTR_WIDTH-1:0]   out_instruction,
  output logic [PC_WIDTH-1:0]      out_pc,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]    pc_mem    [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic empty;
  logic full;
  logic bypass;
  logic push;
  logic pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign in_ready = !full;

`ifdef LAPIDO_FQ_BYPASS_EN
  // An empty queue with a ready consumer forwards the incoming word directly.
  assign bypass = empty & in_valid & out_ready & !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word is consumed at the outputs, so it is neither pushed nor
  // popped; pop is qualified on stored occupancy rather than out_valid.
  assign push = in_valid & in_ready & !flush & !bypass;
  assign pop  = !empty & out_ready & !flush;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    out_valid       = 1'b0;
    out_instruction = '0;
    out_pc          = '0;
    if (!empty) begin
      out_valid       = 1'b1;
      out_instruction = instr_mem[rd_ptr];
      out_pc          = pc_mem[rd_ptr];
    end else if (bypass) begin
      out_valid       = 1'b1;
      out_instruction = in_instruction;
      out_pc          = in_pc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale
  // contents are never observed and the array can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instruction;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

endmodule

// File: tb/tb_lapido_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_lapido_fetch_queue
//
// Directed, table-driven bench for lapido_fetch_queue (DEPTH=4). Each table
// row holds the inputs for one cycle and the outputs expected during that
// cycle, before the next rising edge. Instruction words are derived from the
// PC (0xA000_0000 | pc) so the instruction path is checked along with the PC.
// A hand-written sequence covers asynchronous reset in mid-operation.
// Expectations for the zero-latency path follow LAPIDO_FQ_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_lapido_fetch_queue;

  localparam int IW = 32;
  localparam int PW = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [IW-1:0] in_instruction;
  logic [PW-1:0] in_pc;
  logic          in_ready;
  logic          out_valid;
  logic [IW-1:0] out_instruction;
  logic [PW-1:0] out_pc;
  logic          out_ready;
  logic          flush;
  logic [2:0]    count;

  int checks;
  int errors;

  typedef struct {
    logic          iv;
    logic [PW-1:0] pc;
    logic          ordy;
    logic          fl;
    logic          e_ov;
    logic [PW-1:0] e_pc;
    logic [2:0]    e_cnt;
    logic          e_ir;
  } vec_t;

  vec_t vecs[$];

  lapido_fetch_queue #(
    .INSTR_WIDTH (IW),
    .PC_WIDTH    (PW),
    .DEPTH       (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_instruction  (in_instruction),
    .in_pc           (in_pc),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .out_ready       (out_ready),
    .flush           (flush),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] instr_of(input logic [PW-1:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic e_ov,
                               input logic [PW-1:0] e_pc, input logic [2:0] e_cnt,
                               input logic e_ir);
    logic [IW-1:0] e_instr;
    e_instr = e_ov ? instr_of(e_pc) : '0;
    check({tag, ".out_valid"},       64'(out_valid),       64'(e_ov));
    check({tag, ".out_pc"},          64'(out_pc),          64'(e_pc));
    check({tag, ".out_instruction"}, 64'(out_instruction), 64'(e_instr));
    check({tag, ".count"},           64'(count),           64'(e_cnt));
    check({tag, ".in_ready"},        64'(in_ready),        64'(e_ir));
  endtask

  function automatic vec_t mk(input logic iv, input logic [PW-1:0] pc,
                              input logic ordy, input logic fl,
                              input logic e_ov, input logic [PW-1:0] e_pc,
                              input logic [2:0] e_cnt, input logic e_ir);
    vec_t v;
    v.iv = iv; v.pc = pc; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_ir = e_ir;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [PW-1:0] pc,
                       input logic ordy, input logic fl);
    in_valid       = iv;
    in_pc          = pc;
    in_instruction = instr_of(pc);
    out_ready      = ordy;
    flush          = fl;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Fill: four pushes with ID stalled; head stays at 0x0 once it appears.
    vecs.push_back(mk(1, 32'h00, 0, 0,  0, 32'h00, 3'd0, 1));
    vecs.push_back(mk(1, 32'h04, 0, 0,  1, 32'h00, 3'd1, 1));
    vecs.push_back(mk(1, 32'h08, 0, 0,  1, 32'h00, 3'd2, 1));
    vecs.push_back(mk(1, 32'h0C, 0, 0,  1, 32'h00, 3'd3, 1));
    // Stall while full for 5 cycles, IF keeps offering 0x10: nothing enters.
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 32'h10, 0, 0,  1, 32'h00, 3'd4, 0));
    // One pop from full; in_ready rises the next cycle.
    vecs.push_back(mk(0, 32'h00, 1, 0,  1, 32'h00, 3'd4, 0));
    vecs.push_back(mk(0, 32'h00, 0, 0,  1, 32'h04, 3'd3, 1));
    // Drain the rest in order, then empty outputs read as zero.
    vecs.push_back(mk(0, 32'h00, 1, 0,  1, 32'h04, 3'd3, 1));
    vecs.push_back(mk(0, 32'h00, 1, 0,  1, 32'h08, 3'd2, 1));
    vecs.push_back(mk(0, 32'h00, 1, 0,  1, 32'h0C, 3'd1, 1));
    vecs.push_back(mk(0, 32'h00, 0, 0,  0, 32'h00, 3'd0, 1));
    // Stream at occupancy 2: prime with 0x20, 0x24, then 10 push+pop cycles.
    vecs.push_back(mk(1, 32'h20, 0, 0,  0, 32'h00, 3'd0, 1));
    vecs.push_back(mk(1, 32'h24, 0, 0,  1, 32'h20, 3'd1, 1));
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(1, 32'h28 + 32'(4 * k), 1, 0,
                        1, 32'h20 + 32'(4 * k), 3'd2, 1));
    vecs.push_back(mk(0, 32'h00, 1, 0,  1, 32'h48, 3'd2, 1));
    vecs.push_back(mk(0, 32'h00, 1, 0,  1, 32'h4C, 3'd1, 1));
    vecs.push_back(mk(0, 32'h00, 0, 0,  0, 32'h00, 3'd0, 1));
    // Flush at occupancy 3 with a simultaneous push of 0x40 (dropped).
    vecs.push_back(mk(1, 32'h60, 0, 0,  0, 32'h00, 3'd0, 1));
    vecs.push_back(mk(1, 32'h64, 0, 0,  1, 32'h60, 3'd1, 1));
    vecs.push_back(mk(1, 32'h68, 0, 0,  1, 32'h60, 3'd2, 1));
    vecs.push_back(mk(1, 32'h40, 0, 1,  1, 32'h60, 3'd3, 1));
    vecs.push_back(mk(1, 32'h40, 0, 0,  0, 32'h00, 3'd0, 1));
    vecs.push_back(mk(0, 32'h00, 1, 0,  1, 32'h40, 3'd1, 1));
    vecs.push_back(mk(0, 32'h00, 0, 0,  0, 32'h00, 3'd0, 1));
    // Empty queue, word 0x100 offered with ID ready.
`ifdef LAPIDO_FQ_BYPASS_EN
    vecs.push_back(mk(1, 32'h100, 1, 0, 1, 32'h100, 3'd0, 1));
    vecs.push_back(mk(0, 32'h000, 1, 0, 0, 32'h000, 3'd0, 1));
`else
    vecs.push_back(mk(1, 32'h100, 1, 0, 0, 32'h000, 3'd0, 1));
    vecs.push_back(mk(0, 32'h000, 1, 0, 1, 32'h100, 3'd1, 1));
`endif
    vecs.push_back(mk(0, 32'h000, 0, 0, 0, 32'h000, 3'd0, 1));
    // Flush on an empty queue suppresses both push and forwarding.
    vecs.push_back(mk(1, 32'h200, 1, 1, 0, 32'h000, 3'd0, 1));
    vecs.push_back(mk(0, 32'h000, 1, 0, 0, 32'h000, 3'd0, 1));

    // Reset state, checked while rst is held.
    rst = 1'b1;
    drive(0, '0, 0, 0);
    #2;
    check_outputs("reset", 0, '0, 3'd0, 1);
    #10 rst = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i].iv, vecs[i].pc, vecs[i].ordy, vecs[i].fl);
      #3;
      check_outputs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_pc,
                    vecs[i].e_cnt, vecs[i].e_ir);
    end

    // Asynchronous reset mid-operation: two words queued, then rst mid-cycle.
    @(posedge clk); #1; drive(1, 32'h300, 0, 0);
    @(posedge clk); #1; drive(1, 32'h304, 0, 0);
    @(posedge clk); #1; drive(0, '0, 0, 0);
    #1;
    check_outputs("pre_async_rst", 1, 32'h300, 3'd2, 1);
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 0, '0, 3'd0, 1);
    #1 rst = 1'b0;
    @(posedge clk); #4;
    check_outputs("post_async_rst", 0, '0, 3'd0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
